stack_seq: RTL
==============

Name: stack_seq

Overview:
- Sequences stack operations for the CPU core.
- Accepts push/pop/peek/drop commands, performs the RAM access at the current stack pointer, then pulses the stack-pointer increment or decrement strobe of the base-address register block.
- Sits between the instruction decoder and the data-RAM port and the base-address block.
- Enforces the full and empty limits and prevents a pointer update from colliding with a bus write to the base-address block.

Parameters:
STACK_TOP, 32'h1C00, empty pointer value; equals the reset value of the stack register.
STACK_LIMIT, 32'h1800, full pointer value; push is refused when sp == STACK_LIMIT.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  00 push, 01 pop, 10 peek, 11 drop
cmd_wdata  in  32  push data
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  32  pop/peek read data, held until next rsp_valid
rsp_err  out  1  qualifies rsp_valid: overflow/underflow, no effect
stack_addr  in  32  current stack pointer from base-address block
bus_wr_active  in  1  base-address block being written this cycle (cs_en & wt_en)
stack_inc_en  out  1  one-cycle pointer increment strobe
stack_dec_en  out  1  one-cycle pointer decrement strobe
mem_req  out  1  RAM access request, held until mem_ack
mem_we  out  1  1 write, 0 read
mem_addr  out  32  absolute RAM address
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  access complete, variable latency, >=0 wait cycles

Behaviour:
- Reset (async, rst_n low) values:
  - state = IDLE; cmd_ready = 1.
  - rsp_valid, rsp_err, rsp_data, stack_inc_en, stack_dec_en, mem_req, mem_we, mem_addr and mem_wdata are all 0.
- Reset mid-operation:
  - Any in-flight access is abandoned: mem_req drops immediately and no strobe is issued.
  - The pointer is unchanged by the abandoned operation.
- Stack model: full-descending.
  - Push writes to stack_addr-1, then decrements.
  - Pop reads stack_addr, then increments.
  - Peek reads stack_addr with no adjust.
  - Drop increments with no memory access.
- States: IDLE, MEM, ADJ, ERR.
- IDLE:
  - On cmd_valid, the command is accepted at the clock edge.
  - op, cmd_wdata and the address are latched: push uses stack_addr-1 (32-bit wrap); all others use stack_addr.
  - Push with stack_addr == STACK_LIMIT goes to ERR.
  - Pop, peek or drop with stack_addr == STACK_TOP goes to ERR.
  - Otherwise drop goes to ADJ, and all other ops go to MEM.
- MEM:
  - mem_req = 1; mem_we = 1 for push; mem_addr/mem_wdata come from the latches and are stable until ack.
  - On mem_ack, mem_rdata is captured into rsp_data for pop/peek, then the state goes to ADJ.
  - An ack in the first MEM cycle is legal.
- ADJ:
  - If bus_wr_active = 1: stall with no strobe and no rsp; the bus write has priority in the base-address block and would swallow the strobe.
  - Else, for exactly one cycle:
    - stack_dec_en = 1 for push;
    - stack_inc_en = 1 for pop/drop;
    - neither for peek;
    - rsp_valid = 1, rsp_err = 0.
  - Then the state goes to IDLE.
- ERR: rsp_valid = 1 and rsp_err = 1 for one cycle, with no memory access and no strobe, then IDLE.
- stack_inc_en and stack_dec_en are never both high. Neither is asserted outside ADJ.
- Best-case latency, accept to rsp_valid:
  - push/pop/peek with zero-wait ack: 2 cycles;
  - drop: 1 cycle;
  - error: 1 cycle.
- Back-to-back commands: the next command is accepted the cycle after rsp_valid. The updated stack_addr is valid by then, so no hazard occurs.
- stack_addr is sampled only in IDLE. External writes to the pointer while busy do not affect the current operation.

Decomposition:
- Shared package holds the op encodings (OP_PUSH, OP_POP, OP_PEEK, OP_DROP), the state encodings, and the STACK_TOP/STACK_LIMIT defaults.
- No sub-module: single FSM with a small datapath.

Test Plan:
1. After reset with stack_addr = 32'h1C00: push 32'hDEADBEEF with zero-wait ack -> mem_addr = 32'h1BFF, mem_we = 1, then stack_dec_en pulse and rsp_valid/rsp_err = 0 two cycles after accept.
2. With stack_addr = 32'h1BFF: pop, with mem_ack after 3 wait cycles and mem_rdata = 32'hDEADBEEF -> mem_addr = 32'h1BFF, rsp_data = 32'hDEADBEEF, stack_inc_en pulse, rsp_valid 5 cycles after accept.
3. Pop at stack_addr = 32'h1C00, and push at stack_addr = 32'h1800 -> each gives rsp_err = 1 one cycle after accept, with no mem_req and no strobe.
4. Peek at 32'h1BFE -> read issued, rsp_data returned, no strobes. Drop at 32'h1BFE -> stack_inc_en pulse after 1 cycle, no mem_req.
5. Push with bus_wr_active held high for 2 cycles in ADJ -> stack_dec_en and rsp_valid are delayed exactly 2 cycles and fire once.
6. rst_n low while in MEM waiting for ack -> mem_req drops immediately, no strobe, cmd_ready = 1 after release; a subsequent push completes normally.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// Shared encodings and default pointer limits for the stack sequencer.
package stack_seq_pkg;

    // Command opcodes as presented by the instruction decoder
    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_DROP = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MEM  = 2'b01,
        ST_ADJ  = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // Empty pointer (reset value of the stack register) and full pointer
    localparam logic [31:0] STACK_TOP_DEF   = 32'h0000_1C00;
    localparam logic [31:0] STACK_LIMIT_DEF = 32'h0000_1800;

endpackage : stack_seq_pkg

// File: rtl/stack_seq.sv
// Stack operation sequencer: performs the RAM access for push/pop/peek,
// then pulses the pointer increment/decrement strobe of the base-address
// block, holding the strobe off while that block is being bus-written.
// Full-descending stack: push writes sp-1 then decrements, pop reads sp
// then increments.
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter logic [31:0] STACK_TOP   = STACK_TOP_DEF,
    parameter logic [31:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic [31:0] stack_addr,
    input  logic        bus_wr_active,
    output logic        stack_inc_en,
    output logic        stack_dec_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_e      state_r;
    state_e      state_s;
    op_e         op_r;
    op_e         op_s;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rsp_data_r;
    logic        accept_s;

    assign op_s     = op_e'(cmd_op);
    assign accept_s = (state_r == ST_IDLE) && cmd_valid;

    // State register; async reset abandons any in-flight access at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command latches: stack_addr is sampled only on accept, so pointer
    // writes while busy cannot disturb the current operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= OP_PUSH;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            op_r    <= op_s;
            addr_r  <= (op_s == OP_PUSH) ? (stack_addr - 32'h0000_0001) : stack_addr;
            wdata_r <= cmd_wdata;
        end
    end

    // Read data capture for pop/peek; held until the next read completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_r <= 32'h0000_0000;
        end else if ((state_r == ST_MEM) && mem_ack && (op_r != OP_PUSH)) begin
            rsp_data_r <= mem_rdata;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_s      = state_r;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        stack_inc_en = 1'b0;
        stack_dec_en = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if ((op_s == OP_PUSH) && (stack_addr == STACK_LIMIT)) begin
                        state_s = ST_ERR;
                    end else if ((op_s != OP_PUSH) && (stack_addr == STACK_TOP)) begin
                        state_s = ST_ERR;
                    end else if (op_s == OP_DROP) begin
                        state_s = ST_ADJ;
                    end else begin
                        state_s = ST_MEM;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_r == OP_PUSH);
                if (mem_ack) begin
                    state_s = ST_ADJ;
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_ADJ: begin
                // A bus write to the base-address block would swallow the strobe
                if (bus_wr_active) begin
                    state_s = ST_ADJ;
                end else begin
                    rsp_valid    = 1'b1;
                    stack_dec_en = (op_r == OP_PUSH);
                    stack_inc_en = (op_r == OP_POP) || (op_r == OP_DROP);
                    state_s      = ST_IDLE;
                end
            end
            ST_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign rsp_data  = rsp_data_r;

endmodule : stack_seq
